alu_exec: RTL and testbench

// - Execution-side consumer of the 4-bit alucontrol code produced by the ALU decoder.
// - Sits between register read and writeback in the datapath.
// - Performs the operation selected by alucontrol on srca/srcb under a valid/ready handshake.
// - Shifts (sll/srl) run iteratively, 1 bit per cycle; all other ops complete in 1 cycle.
// - Adds zero and illegal-code status alongside the result.

---
 rtl/alu_exec_if.sv | 36 +++
 rtl/alu_exec.sv | 121 ++++++++++++
 tb/tb_alu_exec.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_if
// Description : Request/response bundle between the register-read stage and
//               the alu_exec execution unit (valid/ready on both sides).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  // Requester side: issues operations and consumes results
  modport master (
    output in_valid, alucontrol, srca, srcb, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  // Execution-unit side
  modport slave (
    input  in_valid, alucontrol, srca, srcb, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : Executes the 4-bit alucontrol operation on srca/srcb under a
//               valid/ready handshake. Logic/arith ops finish in one cycle;
//               sll/srl shift the result register one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic      clk,
  input  logic      reset_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] result_reg;
  logic [SHW-1:0]   cnt;
  logic             shift_left;
  logic             illegal_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic             is_shift;

  // Single-cycle operation result; for shifts this is the unshifted source
  // that the SHIFT state then walks one bit per cycle.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (bus.alucontrol)
      OP_AND:         alu_result = bus.srca & bus.srcb;
      OP_OR:          alu_result = bus.srca | bus.srcb;
      OP_ADD:         alu_result = bus.srca + bus.srcb;
      OP_SUB:         alu_result = bus.srca - bus.srcb;
      OP_SLTU:        alu_result = {{(WIDTH-1){1'b0}}, (bus.srca < bus.srcb)};
      OP_SLL, OP_SRL: alu_result = bus.srcb;
      default:        alu_illegal = 1'b1;
    endcase
  end

  assign is_shift = (bus.alucontrol == OP_SLL) || (bus.alucontrol == OP_SRL);

  // Control FSM with registered handshake outputs and the result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      result_reg    <= '0;
      cnt           <= '0;
      shift_left    <= 1'b0;
      illegal_reg   <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            result_reg   <= alu_result;
            illegal_reg  <= alu_illegal;
            cnt          <= bus.shamt;
            shift_left   <= (bus.alucontrol == OP_SLL);
            in_ready_reg <= 1'b0;
            if (is_shift && (bus.shamt != '0)) begin
              state <= SHIFT;
            end else begin
              state         <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        SHIFT: begin
          result_reg <= shift_left ? (result_reg << 1) : (result_reg >> 1);
          cnt        <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  // zero is gated by out_valid so it reads 0 out of reset and between results
  assign bus.zero      = out_valid_reg && (result_reg == '0);
  assign bus.result    = result_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec
// Description : Self-checking bench for alu_exec: directed corner cases plus
//               randomized operations against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLTU = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1010;
  localparam logic [3:0] C_SRL  = 4'b1100;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  alu_exec #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour: what the op computes and how many edges, counting
  // the accept edge, until out_valid is seen.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] res,
                                output logic ill, output int lat);
    ill = 1'b0;
    lat = 1;
    case (op)
      C_AND:  res = a & b;
      C_OR:   res = a | b;
      C_ADD:  res = a + b;
      C_SUB:  res = a - b;
      C_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      C_SLL:  begin res = b << sh; lat = 1 + int'(sh); end
      C_SRL:  begin res = b >> sh; lat = 1 + int'(sh); end
      default: begin res = 32'd0; ill = 1'b1; end
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, wait for the result,
  // hold it under backpressure for `hold` cycles, then hand it off.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int hold);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          edges;
    model(op, a, b, sh, er, ei, el);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.shamt      = sh;
    bus.out_ready  = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.srca       = $urandom;
    bus.srcb       = $urandom;
    bus.shamt      = 5'($urandom);
    bus.alucontrol = 4'($urandom);
    edges = 1;
    while (!bus.out_valid && edges < 64) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 32'(edges), 32'(el));
    check("result", bus.result, er);
    check("illegal", 32'(bus.illegal), 32'(ei));
    check("zero", 32'(bus.zero), (er == 32'd0) ? 32'd1 : 32'd0);
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", bus.result, er);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'($urandom);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] op_tab [7] = '{C_AND, C_OR, C_ADD, C_SUB, C_SLTU, C_SLL, C_SRL};

  initial begin
    logic [3:0] op;
    bus.in_valid   = 1'b0;
    bus.alucontrol = 4'd0;
    bus.srca       = 32'd0;
    bus.srcb       = 32'd0;
    bus.shamt      = 5'd0;
    bus.out_ready  = 1'b0;

    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    run_op(C_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0, 1);
    run_op(C_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 0);
    run_op(C_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0);
    run_op(C_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3, 0);
    run_op(C_OR,   32'hF000_0000, 32'h0000_000F, 5'd9, 2);
    run_op(C_SLL,  32'h0,         32'h0000_0001, 5'd31, 0);
    run_op(C_SRL,  32'h0,         32'h8000_0000, 5'd0, 0);
    run_op(C_SRL,  32'h0,         32'h8000_0000, 5'd4, 2);
    run_op(C_SLL,  32'h0,         32'h0000_0003, 5'd0, 0);
    run_op(C_ADD,  32'hDEAD_BEEF, 32'h1111_1111, 5'd0, 10);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 0);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1);

    // Reset pulse in the middle of a 20-bit shift
    bus.in_valid   = 1'b1;
    bus.alucontrol = C_SLL;
    bus.srca       = 32'd0;
    bus.srcb       = 32'h0000_0003;
    bus.shamt      = 5'd20;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_illegal", 32'(bus.illegal), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(C_SUB, 32'h0000_0010, 32'h0000_0020, 5'd0, 0);
    run_op(C_SRL, 32'h0,         32'hFFFF_FFFF, 5'd20, 1);

    // Randomized operations, including occasional arbitrary codes
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom);
      else                           op = op_tab[$urandom_range(0, 6)];
      run_op(op, $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
             5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
